// File: rtl/mem_rsp_router.sv
// rtl/mem_rsp_router.sv - LSU request decoder with in-order response return from global/local memory
// Requests are forwarded combinationally; a register FIFO of {target, we, tag} orders the responses.
module mem_rsp_router #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic             req_we_i,
    input  logic [3:0]       req_be_i,
    input  logic [31:0]      req_wdata_i,
    input  logic [TAG_W-1:0] req_tag_i,

    output logic [31:0]      tgt_addr_o,
    output logic             tgt_we_o,
    output logic [3:0]       tgt_be_o,
    output logic [31:0]      tgt_wdata_o,
    output logic             gm_req_valid_o,
    input  logic             gm_req_ready_i,
    output logic             lm_req_valid_o,
    input  logic             lm_req_ready_i,

    input  logic             gm_rsp_valid_i,
    output logic             gm_rsp_ready_o,
    input  logic [31:0]      gm_rsp_rdata_i,
    input  logic             lm_rsp_valid_i,
    output logic             lm_rsp_ready_o,
    input  logic [31:0]      lm_rsp_rdata_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
    output logic             rsp_err_o,
    output logic [TAG_W-1:0] rsp_tag_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] LM_BASE  = 32'h0002_0000;
    localparam logic [31:0] LM_LIMIT = 32'h0003_0000;

    typedef enum logic [1:0] {
        TGT_GM  = 2'd0,
        TGT_LM  = 2'd1,
        TGT_ERR = 2'd2
    } tgt_e;

    tgt_e             dec;
    tgt_e             ent_tgt_q [DEPTH];
    logic [TAG_W-1:0] ent_tag_q [DEPTH];
    logic             ent_we_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    tgt_e             head_tgt;
    logic             head_we;
    logic [TAG_W-1:0] head_tag;

    always_comb begin
        dec = TGT_ERR;
        if (req_addr_i < LM_BASE) begin
            dec = TGT_GM;
        end else if (req_addr_i < LM_LIMIT) begin
            dec = TGT_LM;
        end
    end

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

    // Full is taken from the registered count only, so a same-cycle pop never frees a slot early.
    always_comb begin
        req_ready_o    = 1'b0;
        gm_req_valid_o = 1'b0;
        lm_req_valid_o = 1'b0;
        case (dec)
            TGT_GM: begin
                req_ready_o    = !full && gm_req_ready_i;
                gm_req_valid_o = req_valid_i && !full;
            end
            TGT_LM: begin
                req_ready_o    = !full && lm_req_ready_i;
                lm_req_valid_o = req_valid_i && !full;
            end
            default: begin
                req_ready_o    = !full;
            end
        endcase
    end

    assign tgt_addr_o  = (dec == TGT_LM) ? (req_addr_i - LM_BASE) : req_addr_i;
    assign tgt_we_o    = req_we_i;
    assign tgt_be_o    = req_be_i;
    assign tgt_wdata_o = req_wdata_i;

    assign push     = req_valid_i && req_ready_o;
    assign head_tgt = ent_tgt_q[rd_ptr_q];
    assign head_we  = ent_we_q[rd_ptr_q];
    assign head_tag = ent_tag_q[rd_ptr_q];

    // Only the head's target may hand over data; the other target is held off until its turn.
    always_comb begin
        rsp_valid_o    = 1'b0;
        rsp_err_o      = 1'b0;
        rsp_rdata_o    = '0;
        rsp_tag_o      = '0;
        gm_rsp_ready_o = 1'b0;
        lm_rsp_ready_o = 1'b0;
        if (!empty) begin
            rsp_tag_o = head_tag;
            case (head_tgt)
                TGT_GM: begin
                    rsp_valid_o    = gm_rsp_valid_i;
                    gm_rsp_ready_o = rsp_ready_i;
                    rsp_rdata_o    = head_we ? 32'h0 : gm_rsp_rdata_i;
                end
                TGT_LM: begin
                    rsp_valid_o    = lm_rsp_valid_i;
                    lm_rsp_ready_o = rsp_ready_i;
                    rsp_rdata_o    = head_we ? 32'h0 : lm_rsp_rdata_i;
                end
                default: begin
                    rsp_valid_o = 1'b1;
                    rsp_err_o   = 1'b1;
                end
            endcase
        end
    end

    assign pop = rsp_valid_o && rsp_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_tgt_q[i] <= TGT_GM;
                ent_tag_q[i] <= '0;
                ent_we_q[i]  <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                ent_tgt_q[wr_ptr_q] <= dec;
                ent_tag_q[wr_ptr_q] <= req_tag_i;
                ent_we_q[wr_ptr_q]  <= req_we_i;
            end
        end
    end

endmodule

// File: doc/mem_rsp_router.md
Name: mem_rsp_router

Overview:
- Request-side address decoder and response-side return path between one requester (core LSU port) and the two memory targets of the map: global memory at 0x00000000–0x0001FFFF and local memory at 0x00020000–0x0002FFFF.
- Forwards each request to the decoded target and records the target and tag in an in-order tracking FIFO.
- Returns responses to the requester strictly in request order.
- Generates error responses locally for unmapped addresses.

Parameters:
- DEPTH, 4, maximum outstanding requests (tracking FIFO entries); power of two, ≥2
- TAG_W, 4, requester tag width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  32  byte address
- req_we_i  in  1  write enable
- req_be_i  in  4  byte enables
- req_wdata_i  in  32  write data
- req_tag_i  in  TAG_W  requester tag
- tgt_addr_o  out  32  forwarded address (global: unchanged; local: addr − 0x00020000)
- tgt_we_o / tgt_be_o / tgt_wdata_o  out  1/4/32  forwarded unchanged, shared by both targets
- gm_req_valid_o / gm_req_ready_i  out/in  1  global memory request handshake
- lm_req_valid_o / lm_req_ready_i  out/in  1  local memory request handshake
- gm_rsp_valid_i / gm_rsp_ready_o / gm_rsp_rdata_i  in/out/in  1/1/32  global response
- lm_rsp_valid_i / lm_rsp_ready_o / lm_rsp_rdata_i  in/out/in  1/1/32  local response
- rsp_valid_o  out  1  response to requester
- rsp_ready_i  in  1  requester accepts response
- rsp_rdata_o  out  32  read data (0 for error or write)
- rsp_err_o  out  1  unmapped-address error
- rsp_tag_o  out  TAG_W  tag of the returned request

Behaviour:
- Reset is asynchronous, active-low. All FIFO pointers and count clear. Resulting outputs: req_ready_o=1, rsp_valid_o=0, gm/lm_req_valid_o=0, gm/lm_rsp_ready_o=0, rsp_err_o=0, rsp_rdata_o=0, rsp_tag_o=0.
- Decode (combinational on req_addr_i), start inclusive / end exclusive:
  - addr < 0x20000 → GM (idx 0)
  - 0x20000 ≤ addr < 0x30000 → LM (idx 1)
  - else → ERR (idx 2)
- Target valid: gm_req_valid_o = req_valid_i & dec==GM & !full; lm_req_valid_o is the analogue for LM.
- req_ready_o:
  - !full & gm_req_ready_i for GM
  - !full & lm_req_ready_i for LM
  - !full for ERR
  - full depends on the registered count only; there is no bypass when a pop occurs in the same cycle.
- On request fire, push {target[1:0], tag} into the FIFO. Every request, read or write, produces exactly one response. Targets acknowledge writes with a response.
- Tracking FIFO is register-based, DEPTH entries, with count width $clog2(DEPTH+1). Pointers wrap modulo DEPTH.
- Head entry drives the response path:
  - GM head: rsp_valid_o = gm_rsp_valid_i; gm_rsp_ready_o = rsp_ready_i; rdata from GM.
  - LM head: same with lm_* signals.
  - ERR head: rsp_valid_o = 1, rsp_err_o = 1, rsp_rdata_o = 0.
  - Empty FIFO: rsp_valid_o = 0 and both target rsp_ready_o = 0.
  - rsp_tag_o = head tag.
- The non-head target's rsp_ready_o is held at 0. A response arriving out of order stalls at its target. Each target is required to return its own responses in order.
- Pop on rsp_valid_o & rsp_ready_i.
- Latency:
  - The response path reads only registered FIFO state. A request pushed into an empty FIFO cannot complete in the same cycle; the earliest response is the cycle after request fire (ERR case).
  - Request forwarding is combinational, with zero added latency.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Full: req_ready_o=0 for every target; target req_valid_o is held low.
- Backpressure: rsp_ready_i=0 holds the head, and rsp_rdata_o/tag must stay stable while the target holds its data.
- Reset mid-operation: all outstanding entries are discarded. Responses later returned by targets are not accepted, because rsp_ready_o stays 0 while the FIFO is empty.

Test Plan:
- Read 0x00000104 tag 3, GM rsp rdata 0xDEADBEEF two cycles later → gm_req_valid_o=1, tgt_addr_o=0x104; rsp_valid_o=1, rdata 0xDEADBEEF, tag 3, err 0.
- Write 0x00025000 tag 1 → lm_req_valid_o=1, tgt_addr_o=0x5000, gm_req_valid_o=0; LM ack → rsp tag 1, err 0.
- Read 0x00030000 tag 7 → no target valid; next cycle rsp_valid_o=1, err 1, rdata 0, tag 7.
- Ordering: GM read tag 0 then LM read tag 1; LM responds first with 0x11 and GM responds 3 cycles later with 0x22 → lm_rsp_ready_o=0 until GM popped; outputs are tag 0/0x22 then tag 1/0x11.
- DEPTH=4: four GM requests with no responses → req_ready_o=0 on the fifth; one response popped → req_ready_o=1 next cycle; 12 requests total exercise pointer wrap with tags returned in order.
- Boundary decode: 0x0001FFFC→GM, 0x00020000→LM with tgt_addr 0x0, 0x0002FFFC→LM with tgt_addr 0xFFFC; reset asserted with 2 outstanding → rsp_valid_o=0, req_ready_o=1 immediately.
